// File: rtl/fir_pkg.sv
// Shared FIR definitions: coefficient-bank FSM states, default gain and the
// pass-through coefficient vector used at reset and as a reference.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING
  } coef_state_t;

  localparam int COEFW_DEFAULT = 16;
  localparam int DEFAULT_GAIN  = 2**(COEFW_DEFAULT-1) - 1;

  // Upper bound on NTAPS*COEFW; callers slice the low bits they need.
  localparam int MAX_FLAT = 4096;

  // Pass-through set: h[0] = 2^(coefw-1)-1 (all ones below the sign bit), others 0.
  function automatic logic [MAX_FLAT-1:0] pack_default_coefs(input int coefw);
    logic [MAX_FLAT-1:0] v;
    v = '0;
    for (int b = 0; b < coefw - 1; b++) v[b] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered FIR coefficient store: streams a set into a shadow bank and
// swaps it into the active bank on a sample boundary.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEFW = 16,
  parameter int NTAPS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [COEFW-1:0]       s_data,
  input  logic                   s_last,
  output logic [NTAPS*COEFW-1:0] coef_flat,
  output logic                   pending,
  output logic                   swap_done,
  output logic                   load_err
);

  localparam int CNTW = $clog2(NTAPS);
  localparam int FLAT = NTAPS * COEFW;
  localparam logic [MAX_FLAT-1:0] DEFAULT_WIDE = pack_default_coefs(COEFW);
  localparam logic [FLAT-1:0]     DEFAULT_FLAT = DEFAULT_WIDE[FLAT-1:0];
  localparam logic [CNTW-1:0]     LAST_IDX     = CNTW'(NTAPS - 1);

  coef_state_t      state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [COEFW-1:0] shadow [NTAPS];
  logic [FLAT-1:0]  shadow_flat;
  logic [FLAT-1:0]  active;
  logic             accept;
  logic             swap;
  logic             frame_err;

  // Handshake decoded from state only, so s_ready never depends on s_valid.
  assign s_ready   = (state != PENDING);
  assign pending   = (state == PENDING);
  assign accept    = s_valid & s_ready;
  assign coef_flat = active;

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    swap      = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (s_last) begin
            frame_err = 1'b1;
          end else begin
            state_nxt = LOAD;
            cnt_nxt   = CNTW'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (cnt == LAST_IDX && s_last) begin
            state_nxt = PENDING;
            cnt_nxt   = '0;
          end else if (cnt == LAST_IDX || s_last) begin
            frame_err = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNTW'(1);
          end
        end
      end
      PENDING: begin
        if (sample_en) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NTAPS; k++) shadow_flat[k*COEFW +: COEFW] = shadow[k];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      active    <= DEFAULT_FLAT;
      swap_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      swap_done <= swap;
      load_err  <= frame_err;
      if (swap) active <= shadow_flat;
    end
  end

  // NOTE: the shadow bank has no reset; it is only read after a complete load rewrites it.
  always_ff @(posedge clk) begin
    if (accept) shadow[cnt] <= s_data;
  end

endmodule

// File: tb/tb_fir_coef_bank.sv
// Directed self-checking bench for fir_coef_bank with a swap scoreboard.
module tb_fir_coef_bank;

  localparam int COEFW = 16;
  localparam int NTAPS = 16;
  localparam int FLAT  = NTAPS * COEFW;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_en;
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     s_data;
  logic            s_last;
  logic [FLAT-1:0] coef_flat;
  logic            pending;
  logic            swap_done;
  logic            load_err;

  fir_coef_bank #(.COEFW(COEFW), .NTAPS(NTAPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .coef_flat (coef_flat),
    .pending   (pending),
    .swap_done (swap_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int              checks = 0;
  int              errors = 0;
  int              swaps = 0;
  int              errs_seen = 0;
  int              swaps_ref;
  logic [FLAT-1:0] sb [$];
  logic [15:0]     cset [NTAPS];
  logic [FLAT-1:0] default_flat;
  logic [FLAT-1:0] cur_flat;
  logic [FLAT-1:0] new_flat;

  task automatic check(input string tag, input logic [FLAT-1:0] obs, input logic [FLAT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last, input logic se);
    s_valid   = 1'b1;
    s_data    = d;
    s_last    = last;
    sample_en = se;
    tick();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    sample_en = 1'b0;
  endtask

  task automatic load_set(input logic se_on_last);
    for (int k = 0; k < NTAPS; k++) send(cset[k], k == NTAPS - 1, se_on_last && k == NTAPS - 1);
  endtask

  function automatic logic [FLAT-1:0] pack_set();
    logic [FLAT-1:0] v;
    v = '0;
    for (int k = 0; k < NTAPS; k++) v[k*COEFW +: COEFW] = cset[k];
    return v;
  endfunction

  // Scoreboard: each swap_done pulse pops the set expected to be active.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (swap_done === 1'b1) begin
        swaps++;
        check("sb_nonempty", FLAT'(sb.size() != 0), FLAT'(1));
        if (sb.size() != 0) check("swap_data", coef_flat, sb.pop_front());
      end
      if (load_err === 1'b1) errs_seen++;
    end
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    default_flat = FLAT'(16'h7FFF);

    // Reset default
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("rst_coef", coef_flat, default_flat);
    check("rst_ready", FLAT'(s_ready), FLAT'(1));
    check("rst_pending", FLAT'(pending), FLAT'(0));
    check("rst_swap_done", FLAT'(swap_done), FLAT'(0));
    check("rst_load_err", FLAT'(load_err), FLAT'(0));
    cur_flat = default_flat;

    // Full load with sample_en every 4th cycle (including the final beat)
    for (int k = 0; k < NTAPS; k++) cset[k] = 16'(16000 >> k);
    new_flat = pack_set();
    for (int k = 0; k < NTAPS; k++) send(cset[k], k == NTAPS - 1, (k % 4) == 3);
    check("load_ready_low", FLAT'(s_ready), FLAT'(0));
    check("load_pending", FLAT'(pending), FLAT'(1));
    check("load_coef_hold", coef_flat, cur_flat);
    repeat (3) tick();
    check("pend_coef_hold", coef_flat, cur_flat);
    sample_en = 1'b1;
    sb.push_back(new_flat);
    tick();
    sample_en = 1'b0;
    check("swap_coef", coef_flat, new_flat);
    check("swap_pending", FLAT'(pending), FLAT'(0));
    check("swap_ready", FLAT'(s_ready), FLAT'(1));
    check("swap_done_hi", FLAT'(swap_done), FLAT'(1));
    tick();
    check("swap_done_lo", FLAT'(swap_done), FLAT'(0));
    check("swap_count1", FLAT'(swaps), FLAT'(1));
    cur_flat = new_flat;

    // Same-cycle boundary, then several sample_en pulses in PENDING
    for (int k = 0; k < NTAPS; k++) cset[k] = 16'(k * 100 - 700);
    new_flat = pack_set();
    load_set(1'b1);
    check("same_cycle_pending", FLAT'(pending), FLAT'(1));
    check("same_cycle_hold", coef_flat, cur_flat);
    tick();
    check("same_cycle_hold2", coef_flat, cur_flat);
    sample_en = 1'b1;
    sb.push_back(new_flat);
    repeat (3) tick();
    sample_en = 1'b0;
    tick();
    check("multi_se_coef", coef_flat, new_flat);
    check("multi_se_one_swap", FLAT'(swaps), FLAT'(2));
    cur_flat = new_flat;

    // Framing error: s_last on beat 5
    for (int k = 0; k < NTAPS; k++) cset[k] = 16'($urandom);
    for (int k = 0; k < 5; k++) send(cset[k], k == 4, 1'b0);
    check("err_early_pulse", FLAT'(load_err), FLAT'(1));
    check("err_early_pending", FLAT'(pending), FLAT'(0));
    tick();
    check("err_early_pulse_end", FLAT'(load_err), FLAT'(0));
    check("err_early_coef", coef_flat, cur_flat);

    // Framing error: 16 beats without s_last
    for (int k = 0; k < NTAPS; k++) send(cset[k], 1'b0, 1'b0);
    check("err_nolast_pulse", FLAT'(load_err), FLAT'(1));
    tick();
    check("err_count", FLAT'(errs_seen), FLAT'(2));
    check("err_nolast_coef", coef_flat, cur_flat);
    check("err_nolast_pending", FLAT'(pending), FLAT'(0));

    // Correct load after errors
    new_flat = pack_set();
    load_set(1'b0);
    tick();
    sample_en = 1'b1;
    sb.push_back(new_flat);
    tick();
    sample_en = 1'b0;
    check("recover_coef", coef_flat, new_flat);
    tick();
    check("recover_swaps", FLAT'(swaps), FLAT'(3));
    cur_flat = new_flat;

    // Sign and backpressure
    for (int k = 0; k < NTAPS; k++) cset[k] = '0;
    cset[0] = 16'h8001;
    new_flat = pack_set();
    load_set(1'b0);
    s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_ready_low", FLAT'(s_ready), FLAT'(0));
    end
    sample_en = 1'b1;
    sb.push_back(new_flat);
    tick();
    sample_en = 1'b0;
    s_valid = 1'b0;
    check("sign_h0", FLAT'(coef_flat[15:0]), FLAT'(16'h8001));
    check("sign_coef", coef_flat, new_flat);
    tick();
    check("sign_swaps", FLAT'(swaps), FLAT'(4));
    cur_flat = new_flat;

    // A clean load after backpressure proves no stray beat was taken; reset while PENDING
    for (int k = 0; k < NTAPS; k++) cset[k] = 16'(k + 1);
    load_set(1'b0);
    check("post_bp_pending", FLAT'(pending), FLAT'(1));
    check("post_bp_no_err", FLAT'(errs_seen), FLAT'(2));
    swaps_ref = swaps;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pend_coef", coef_flat, default_flat);
    check("rst_pend_pending", FLAT'(pending), FLAT'(0));
    check("rst_pend_ready", FLAT'(s_ready), FLAT'(1));
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    check("rst_pend_no_swap", FLAT'(swaps), FLAT'(swaps_ref));
    check("rst_pend_coef2", coef_flat, default_flat);

    // Reset mid-load after 8 beats
    for (int k = 0; k < 8; k++) send(cset[k], 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_load_coef", coef_flat, default_flat);
    check("rst_load_pending", FLAT'(pending), FLAT'(0));
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    check("rst_load_no_swap", FLAT'(swaps), FLAT'(swaps_ref));
    check("rst_load_coef2", coef_flat, default_flat);

    check("sb_drained", FLAT'(sb.size()), FLAT'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coef_bank.md
# fir_coef_bank

Double-buffered coefficient store that drives the `coef_flat` input of `fir_core`. It accepts a coefficient set as a valid/ready stream (h[0] first) into a shadow bank. It then swaps the shadow bank into the active bank atomically on a sample boundary, so the filter never runs with a half-written coefficient set. It sits between the control/register path and `fir_core`, in the `fir_core` clock domain.

## Interface
- `COEFW`, 16, coefficient width (signed Q1.15 at default)
- `NTAPS`, 16, number of taps; ≥ 2
- `CNTW`, $clog2(NTAPS), beat counter width (derived, not overridden)
- `clk` in 1: clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `sample_en` in 1: sample strobe; the same signal as `fir_core.en`
- `s_valid` in 1: coefficient beat valid
- `s_ready` out 1: coefficient beat accepted when `s_valid & s_ready`
- `s_data` in COEFW: signed coefficient, in tap order h[0]..h[NTAPS-1]
- `s_last` in 1: marks h[NTAPS-1]
- `coef_flat` out NTAPS*COEFW: active bank; h[k] occupies bits [k*COEFW +: COEFW]
- `pending` out 1: a complete set is waiting for a swap
- `swap_done` out 1: one-cycle pulse, cycle after the active bank updates
- `load_err` out 1: one-cycle pulse on a framing error

## Operation
- FSM states are IDLE, LOAD and PENDING.
- IDLE: the first accepted beat writes shadow[0], sets cnt=1 and goes to LOAD. If that beat also has `s_last`, it is a framing error.
- LOAD: each accepted beat writes shadow[cnt] and increments cnt.
  - Beat with `s_last` and cnt==NTAPS-1: go to PENDING.
  - Beat with `s_last` and cnt<NTAPS-1: framing error.
  - Beat at cnt==NTAPS-1 without `s_last`: framing error.
- Framing error handling:
  - Pulse `load_err`, reset cnt to 0 and go to IDLE.
  - The shadow bank contents are don't-care.
  - The active bank is untouched.
- PENDING: `s_ready`=0. When `sample_en`=1, copy the active bank from the shadow bank in one edge, pulse `swap_done` on the next cycle and return to IDLE.
- `s_ready` = (state != PENDING). It is decoded from the state register only and does not depend on `s_valid`.
- There is no arithmetic. Coefficients pass through bit-exact and sign is preserved.
- Reset default for the active bank is pass-through: h[0]=2^(COEFW-1)-1 (32767 at default), all other taps 0.

## Timing
- Reset state: IDLE, cnt=0, `s_ready`=1, `pending`=0, `swap_done`=0, `load_err`=0. `coef_flat` holds the pass-through default, visible in the first cycle after `rst` is released.
- `coef_flat` is a direct register output with no combinational path from inputs.
- The final beat is accepted at edge N and PENDING is entered at edge N.
  - A `sample_en` in the same cycle as that final beat does not swap. The swap uses the first `sample_en` sampled in PENDING, i.e. at edge ≥ N+1.
- Swap at edge S:
  - `coef_flat` shows the new set from S.
  - `swap_done`=1 during the cycle after S.
  - `pending` falls at S.
  - `s_ready` returns to 1 at S.
- Minimum load-to-swap latency is NTAPS accepted beats plus 1 `sample_en` cycle.
- `load_err` is asserted for the single cycle following the offending beat's edge.
- `rst` mid-load or in PENDING returns to IDLE and discards the shadow bank. The active bank reverts to the default (reset is global).
- `sample_en` in IDLE or LOAD has no effect.
- Multiple `sample_en` pulses in PENDING produce exactly one swap.

## Structure
- Shared package `fir_pkg` holds:
  - `coef_state_t` enum (IDLE, LOAD, PENDING)
  - `DEFAULT_GAIN` constant (2^(COEFW-1)-1)
  - function `pack_default_coefs` that returns the pass-through flat vector, for RTL reset and bench reference
- No sub-module: one FSM, one counter, two register banks. Expected RTL size is 150–250 lines.

## Test plan
- **Reset default:** assert `rst` for 4 cycles, then release → `coef_flat[15:0]`=32767, all other taps 0, `s_ready`=1, no pulses.
- **Full load and swap:** load 16 beats h[k]=16000>>>k with `s_last` on beat 16, with `sample_en` every 4th cycle.
  - `s_ready`=0 after beat 16.
  - `coef_flat` is unchanged until the first `sample_en` in PENDING, then equals the new set bit-exact.
  - `swap_done` is a single pulse one cycle later.
- **Same-cycle boundary:** final beat coincides with `sample_en` → no swap on that edge; swap on the next `sample_en`.
- **Framing errors:**
  - `s_last` on beat 5 → `load_err` pulse, `coef_flat` unchanged.
  - 16 beats without `s_last` → `load_err` on beat 16.
  - A following correct load swaps normally.
- **Sign and backpressure:** load h[0]=-32767 and the rest 0, hold `s_valid`=1 through PENDING → no beats accepted while `s_ready`=0. After the swap, `coef_flat[15:0]`=16'h8001.
- **Reset mid-operation:** `rst` pulse after 8 beats, and separately in PENDING → IDLE, no swap, `coef_flat` = default, `pending`=0.
